// File: rtl/rx78_vram_pkg.sv
// Shared types and constants for the RX-78 VRAM arbitration slice.
// The six 8-bit planes (fg1-3, bg1-3) share one address bus. The CPU
// window and the scanout fetcher take turns on that bus through
// vram_arbiter.
package rx78_vram_pkg;

  localparam int         ADDR_W      = 13;
  localparam int         PLANES      = 6;
  localparam logic [7:0] RD_OPEN_BUS = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_VID
  } owner_t;

endpackage

// File: rtl/vram_rd_bank_sel.sv
// Selects one plane byte out of the concatenated plane read data, using
// the CPU read-plane register.
//   rd_bank    : read-plane register (1..6 selects plane 0..5)
//   mem_q      : all planes, plane n at [8n+7:8n]
//   plane_byte : selected byte; open bus (FF) for any other rd_bank value
module vram_rd_bank_sel #(
  parameter int PLANES = rx78_vram_pkg::PLANES
) (
  input  logic [7:0]          rd_bank,
  input  logic [8*PLANES-1:0] mem_q,
  output logic [7:0]          plane_byte
);
  import rx78_vram_pkg::*;

  always_comb begin
    plane_byte = RD_OPEN_BUS;
    for (int n = 0; n < PLANES; n++) begin
      if (rd_bank == 8'(n + 1)) plane_byte = mem_q[8*n +: 8];
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Time-shares the single-port VRAM planes between the Z80 memory window
// and the scanout fetcher.
//   clk, reset_n          : clock, async active-low reset
//   cpu_req/we/addr/din   : CPU access (level request), held while stalled
//   rd_bank, wr_mask      : read-plane select and per-plane write enables
//   cpu_dout, cpu_wait_n  : CPU read data, stall (low = wait)
//   vid_req/vid_addr      : fetcher request (level)
//   vid_ack, vid_data     : one-cycle completion pulse, all-plane data
//   mem_addr/din/we/q     : shared plane bus; mem_q is valid one cycle after mem_addr
module vram_arbiter #(
  parameter int ADDR_W     = rx78_vram_pkg::ADDR_W,
  parameter int PLANES     = rx78_vram_pkg::PLANES,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [7:0]          cpu_din,
  input  logic [7:0]          rd_bank,
  input  logic [PLANES-1:0]   wr_mask,
  output logic [7:0]          cpu_dout,
  output logic                cpu_wait_n,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_ack,
  output logic [8*PLANES-1:0] vid_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_din,
  output logic [PLANES-1:0]   mem_we,
  input  logic [8*PLANES-1:0] mem_q
);
  import rx78_vram_pkg::*;

  localparam int            SW  = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  state_t              state_q, state_d;
  owner_t              owner_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic                we_p0;
  logic [7:0]          din_p0;
  logic [PLANES-1:0]   mask_p0;
  logic [7:0]          bank_p0;
  logic [SW-1:0]       streak_q;
  logic                grant_vid, grant_cpu, cpu_done;
  logic [7:0]          rd_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Video wins ties until it has starved a pending CPU for STARVE_LIM grants.
  always_comb begin
    state_d   = state_q;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    mem_we    = '0;
    vid_ack   = 1'b0;
    cpu_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vid_req && !(cpu_req && streak_q == LIM)) begin
          grant_vid = 1'b1;
          state_d   = ST_ACCESS;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (owner_p0 == OWN_CPU && we_p0) begin
          mem_we  = mask_p0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: state_d = ST_DONE;
      ST_DONE: begin
        vid_ack  = (owner_p0 == OWN_VID);
        cpu_done = (owner_p0 == OWN_CPU);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant stage: operands are frozen here and held until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_p0 <= OWN_CPU;
      addr_p0  <= '0;
      we_p0    <= 1'b0;
      din_p0   <= '0;
      mask_p0  <= '0;
      bank_p0  <= '0;
    end else if (grant_vid) begin
      owner_p0 <= OWN_VID;
      addr_p0  <= vid_addr;
      we_p0    <= 1'b0;
    end else if (grant_cpu) begin
      owner_p0 <= OWN_CPU;
      addr_p0  <= cpu_addr;
      we_p0    <= cpu_we;
      din_p0   <= cpu_din;
      mask_p0  <= wr_mask;
      bank_p0  <= rd_bank;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (!cpu_req || grant_cpu)            streak_q <= '0;
      else if (grant_vid && streak_q < LIM) streak_q <= streak_q + SW'(1);
    end
  end

  vram_rd_bank_sel #(.PLANES(PLANES)) u_rd_sel (
    .rd_bank    (bank_p0),
    .mem_q      (mem_q),
    .plane_byte (rd_byte)
  );

  // Capture stage: mem_q reflects the ACCESS-cycle address during WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_data <= '0;
      cpu_dout <= RD_OPEN_BUS;
    end else if (state_q == ST_WAIT) begin
      if (owner_p0 == OWN_VID) vid_data <= mem_q;
      else                     cpu_dout <= rd_byte;
    end
  end

  assign mem_addr   = addr_p0;
  assign mem_din    = din_p0;
  // Held high through reset so a CPU parked on the window is not frozen.
  assign cpu_wait_n = ~reset_n | ~cpu_req | cpu_done;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int NP = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din, rd_bank;
  logic [NP-1:0] wr_mask;
  logic [7:0]    cpu_dout;
  logic          cpu_wait_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [8*NP-1:0] vid_data;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [NP-1:0] mem_we;
  logic [8*NP-1:0] mem_q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .PLANES(NP), .STARVE_LIM(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .rd_bank(rd_bank), .wr_mask(wr_mask), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_q(mem_q)
  );

  // Synchronous single-port plane RAMs; known contents are loaded while reset is low.
  // 0x040: A1 B2 C3 D4 E5 F6 (plane 0..5); 0x123: plane1=77, others 00;
  // 0x200+k: plane n = 0x10*(n+1)+k.
  logic [7:0] vram [NP][8192];
  always @(posedge clk) begin
    for (int n = 0; n < NP; n++) begin
      if (!reset_n) begin
        vram[n][13'h040] <= 8'(161 + 17 * n);
        vram[n][13'h123] <= (n == 1) ? 8'h77 : 8'h00;
        for (int k = 0; k < 8; k++) vram[n][13'(512 + k)] <= 8'(16 * (n + 1) + k);
      end else if (mem_we[n]) begin
        vram[n][mem_addr] <= mem_din;
      end
      mem_q[8*n +: 8] <= vram[n][mem_addr];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 100000)", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    rd_bank = 8'd0; wr_mask = '0; vid_req = 1'b0; vid_addr = '0;
    repeat (3) tick();
    n_cmp++; if (mem_we !== 6'b0) begin n_bad++; $display("FAIL rst_mem_we got %b want 000000", mem_we); end
    n_cmp++; if (mem_addr !== 13'h0) begin n_bad++; $display("FAIL rst_mem_addr got %h want 0000", mem_addr); end
    n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL rst_mem_din got %h want 00", mem_din); end
    n_cmp++; if (vid_ack !== 1'b0) begin n_bad++; $display("FAIL rst_vid_ack got %b want 0", vid_ack); end
    n_cmp++; if (vid_data !== 48'h0) begin n_bad++; $display("FAIL rst_vid_data got %h want 0", vid_data); end
    n_cmp++; if (cpu_dout !== 8'hFF) begin n_bad++; $display("FAIL rst_cpu_dout got %h want FF", cpu_dout); end
    n_cmp++; if (cpu_wait_n !== 1'b1) begin n_bad++; $display("FAIL rst_wait_n got %b want 1", cpu_wait_n); end
    cpu_req = 1'b0;
    reset_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_cpu_write();
    cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_din = 8'h5A; wr_mask = 6'b000101; cpu_req = 1'b1;
    #1;
    n_cmp++; if (cpu_wait_n !== 1'b0) begin n_bad++; $display("FAIL wr_c0_wait_n got %b want 0", cpu_wait_n); end
    tick();
    n_cmp++; if (mem_we !== 6'b000101) begin n_bad++; $display("FAIL wr_c1_mem_we got %b want 000101", mem_we); end
    n_cmp++; if (mem_addr !== 13'h0123) begin n_bad++; $display("FAIL wr_c1_mem_addr got %h want 0123", mem_addr); end
    n_cmp++; if (mem_din !== 8'h5A) begin n_bad++; $display("FAIL wr_c1_mem_din got %h want 5a", mem_din); end
    n_cmp++; if (cpu_wait_n !== 1'b0) begin n_bad++; $display("FAIL wr_c1_wait_n got %b want 0", cpu_wait_n); end
    tick();
    n_cmp++; if (cpu_wait_n !== 1'b1) begin n_bad++; $display("FAIL wr_c2_wait_n got %b want 1", cpu_wait_n); end
    n_cmp++; if (mem_we !== 6'b0) begin n_bad++; $display("FAIL wr_c2_mem_we got %b want 000000", mem_we); end
    cpu_req = 1'b0;
    tick();
    n_cmp++; if (mem_we !== 6'b0) begin n_bad++; $display("FAIL wr_c3_mem_we got %b want 000000", mem_we); end
    n_cmp++; if (vram[0][13'h123] !== 8'h5A) begin n_bad++; $display("FAIL wr_plane0 got %h want 5a", vram[0][13'h123]); end
    n_cmp++; if (vram[1][13'h123] !== 8'h77) begin n_bad++; $display("FAIL wr_plane1 got %h want 77", vram[1][13'h123]); end
    n_cmp++; if (vram[2][13'h123] !== 8'h5A) begin n_bad++; $display("FAIL wr_plane2 got %h want 5a", vram[2][13'h123]); end
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [7:0] bank,
                          input logic [7:0] exp, input string tag);
    cpu_we = 1'b0; cpu_addr = a; rd_bank = bank; cpu_req = 1'b1;
    #1;
    tick();
    n_cmp++; if (mem_addr !== a) begin n_bad++; $display("FAIL %s_c1_mem_addr got %h want %h", tag, mem_addr, a); end
    n_cmp++; if (cpu_wait_n !== 1'b0) begin n_bad++; $display("FAIL %s_c1_wait_n got %b want 0", tag, cpu_wait_n); end
    tick();
    n_cmp++; if (cpu_wait_n !== 1'b0) begin n_bad++; $display("FAIL %s_c2_wait_n got %b want 0", tag, cpu_wait_n); end
    tick();
    n_cmp++; if (cpu_wait_n !== 1'b1) begin n_bad++; $display("FAIL %s_c3_wait_n got %b want 1", tag, cpu_wait_n); end
    n_cmp++; if (cpu_dout !== exp) begin n_bad++; $display("FAIL %s_dout got %h want %h", tag, cpu_dout, exp); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_read(13'h040, 8'd3, 8'hC3, "rd_bank3");
    cpu_read(13'h040, 8'd0, 8'hFF, "rd_bank0");
    cpu_read(13'h040, 8'd6, 8'hF6, "rd_bank6");
    cpu_read(13'h040, 8'd7, 8'hFF, "rd_bank7");
  endtask

  task automatic test_simultaneous();
    vid_addr = 13'h200; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 13'h040; rd_bank = 8'd1; cpu_req = 1'b1;
    #1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      n_cmp++; if (vid_ack !== 1'(c == 3)) begin n_bad++; $display("FAIL sim_vid_ack_c%0d got %b want %b", c, vid_ack, (c == 3)); end
      n_cmp++; if (cpu_wait_n !== 1'(c == 7)) begin n_bad++; $display("FAIL sim_wait_n_c%0d got %b want %b", c, cpu_wait_n, (c == 7)); end
      if (c == 1) begin
        n_cmp++; if (mem_addr !== 13'h200) begin n_bad++; $display("FAIL sim_vid_addr got %h want 0200", mem_addr); end
      end
      if (c == 3) begin
        n_cmp++; if (vid_data !== 48'h605040302010) begin n_bad++; $display("FAIL sim_vid_data got %h want 605040302010", vid_data); end
        vid_req = 1'b0;
      end
      if (c == 5) begin
        n_cmp++; if (mem_addr !== 13'h040) begin n_bad++; $display("FAIL sim_cpu_addr got %h want 0040", mem_addr); end
      end
      if (c == 7) begin
        n_cmp++; if (cpu_dout !== 8'hA1) begin n_bad++; $display("FAIL sim_cpu_dout got %h want a1", cpu_dout); end
        cpu_req = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_starvation();
    byte ev [6];
    int  ev_n = 0;
    int  cpu_cycle = -1;
    for (int i = 0; i < 6; i++) ev[i] = "-";
    vid_addr = 13'h200; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 13'h040; rd_bank = 8'd2; cpu_req = 1'b1;
    #1;
    for (int c = 1; c <= 80 && ev_n < 6; c++) begin
      tick();
      if (vid_ack) begin
        ev[ev_n] = "V"; ev_n++;
        if (ev_n == 1) begin
          n_cmp++; if (vid_data !== 48'h605040302010) begin n_bad++; $display("FAIL stv_ack1_data got %h want 605040302010", vid_data); end
        end
        if (ev_n == 2) begin
          n_cmp++; if (vid_data !== 48'h615141312111) begin n_bad++; $display("FAIL stv_ack2_data got %h want 615141312111", vid_data); end
        end
        vid_addr = vid_addr + 13'd1;
      end else if (cpu_req && cpu_wait_n) begin
        ev[ev_n] = "C"; ev_n++;
        cpu_cycle = c;
        n_cmp++; if (cpu_dout !== 8'hB2) begin n_bad++; $display("FAIL stv_cpu_dout got %h want b2", cpu_dout); end
        cpu_req = 1'b0;
      end
    end
    n_cmp++; if (ev_n != 6) begin n_bad++; $display("FAIL stv_event_count got %0d want 6 (cycle budget expired)", ev_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (ev[i] != "V") begin n_bad++; $display("FAIL stv_event%0d got %c want V", i, ev[i]); end
    end
    n_cmp++; if (ev[4] != "C") begin n_bad++; $display("FAIL stv_event4 got %c want C", ev[4]); end
    n_cmp++; if (ev[5] != "V") begin n_bad++; $display("FAIL stv_event5 got %c want V", ev[5]); end
    n_cmp++; if (cpu_cycle != 19) begin n_bad++; $display("FAIL stv_cpu_cycle got %0d want 19", cpu_cycle); end
    vid_req = 1'b0; cpu_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_write_mask0();
    logic seen_we;
    seen_we = 1'b0;
    cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_din = 8'h99; wr_mask = 6'b0; cpu_req = 1'b1;
    #1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (mem_we !== 6'b0) seen_we = 1'b1;
      if (c == 1) begin
        n_cmp++; if (cpu_wait_n !== 1'b0) begin n_bad++; $display("FAIL m0_c1_wait_n got %b want 0", cpu_wait_n); end
      end
      if (c == 2) begin
        n_cmp++; if (cpu_wait_n !== 1'b1) begin n_bad++; $display("FAIL m0_c2_wait_n got %b want 1", cpu_wait_n); end
        cpu_req = 1'b0;
      end
    end
    n_cmp++; if (seen_we !== 1'b0) begin n_bad++; $display("FAIL m0_mem_we_seen got %b want 0", seen_we); end
    n_cmp++; if (vram[0][13'h123] !== 8'h5A) begin n_bad++; $display("FAIL m0_plane0 got %h want 5a", vram[0][13'h123]); end
    n_cmp++; if (vram[1][13'h123] !== 8'h77) begin n_bad++; $display("FAIL m0_plane1 got %h want 77", vram[1][13'h123]); end
  endtask

  task automatic test_reset_mid();
    cpu_we = 1'b0; cpu_addr = 13'h040; rd_bank = 8'd3; cpu_req = 1'b1;
    #1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 6'b0) begin n_bad++; $display("FAIL rm_mem_we got %b want 000000", mem_we); end
    n_cmp++; if (cpu_wait_n !== 1'b1) begin n_bad++; $display("FAIL rm_wait_n got %b want 1", cpu_wait_n); end
    n_cmp++; if (cpu_dout !== 8'hFF) begin n_bad++; $display("FAIL rm_cpu_dout got %h want FF", cpu_dout); end
    n_cmp++; if (vid_data !== 48'h0) begin n_bad++; $display("FAIL rm_vid_data got %h want 0", vid_data); end
    n_cmp++; if (mem_addr !== 13'h0) begin n_bad++; $display("FAIL rm_mem_addr got %h want 0000", mem_addr); end
    tick();
    n_cmp++; if (cpu_dout !== 8'hFF) begin n_bad++; $display("FAIL rm_hold_dout got %h want FF", cpu_dout); end
    n_cmp++; if (vid_ack !== 1'b0) begin n_bad++; $display("FAIL rm_hold_vid_ack got %b want 0", vid_ack); end
    n_cmp++; if (cpu_wait_n !== 1'b1) begin n_bad++; $display("FAIL rm_hold_wait_n got %b want 1", cpu_wait_n); end
    tick();
    reset_n = 1'b1;
    #1;
    n_cmp++; if (cpu_wait_n !== 1'b0) begin n_bad++; $display("FAIL rm_rel_c0_wait_n got %b want 0", cpu_wait_n); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++; if (cpu_wait_n !== 1'(c == 3)) begin n_bad++; $display("FAIL rm_rel_c%0d_wait_n got %b want %b", c, cpu_wait_n, (c == 3)); end
    end
    n_cmp++; if (cpu_dout !== 8'hC3) begin n_bad++; $display("FAIL rm_rel_dout got %h want c3", cpu_dout); end
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_simultaneous();
    test_starvation();
    test_write_mask0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the six single-port 8K VRAM planes between the Z80 memory window (EC00-FFFF) and the gfx scanout fetcher.
- Handles the plane write mask (port F2) and the read-plane select (port F1).
- Stalls the CPU through wait_n while the video fetcher holds the memory.
- Sits between the CPU decode and the VRAM instances, replacing direct dual-port access.

Parameters:
ADDR_W, 13, VRAM word address width per plane
PLANES, 6, number of 8-bit planes (fg1-3, bg1-3)
STARVE_LIM, 4, consecutive video grants allowed while CPU pending before CPU is forced in

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  level; CPU VRAM access pending (vram_en)
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU VRAM address
cpu_din  in  8  CPU write data
rd_bank  in  8  read-plane register (1..6 selects plane 0..5)
wr_mask  in  PLANES  plane write enables (bit n writes plane n)
cpu_dout  out  8  CPU read data
cpu_wait_n  out  1  low = stall CPU
vid_req  in  1  level; fetcher wants vid_addr
vid_addr  in  ADDR_W  fetch address
vid_ack  out  1  one-cycle pulse; vid_data valid
vid_data  out  8*PLANES  all planes, plane n at [8n+7:8n]
mem_addr  out  ADDR_W  shared address to all planes
mem_din  out  8  write data to all planes
mem_we  out  PLANES  per-plane write strobe
mem_q  in  8*PLANES  plane read data, valid 1 cycle after mem_addr

Behaviour:
- Reset (async assert, sync release): state IDLE; mem_we=0, mem_addr=0, mem_din=0, vid_ack=0, vid_data=0, cpu_dout=8'hFF, streak=0. cpu_wait_n=1 while reset_n low.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE arbitration: choose video if vid_req and not (cpu_req and streak==STARVE_LIM); else CPU if cpu_req; else stay. Latch owner, address, we, data, mask. Go to ACCESS.
- ACCESS: mem_addr=latched address.
  - CPU write: mem_we=latched wr_mask, mem_din=cpu_din, next DONE.
  - Read: next WAIT.
- WAIT: register mem_q into vid_data (video) or the selected plane into cpu_dout (CPU); next DONE.
- rd_bank outside 1..6 gives cpu_dout=8'hFF.
- DONE: vid_ack=1 for a video grant, CPU completion for a CPU grant; next IDLE.
- Latency from request sampled in IDLE (cycle 0): read DONE at cycle 3, write DONE at cycle 2. Next grant earliest at cycle 4 (read) or 3 (write).
- cpu_wait_n = ~cpu_req | (state==DONE & owner==CPU). It goes low combinationally the cycle cpu_req rises.
- Requester handshake: a requester must drop or change its request the cycle after its completion. A request still held in IDLE is serviced again.
- Write with wr_mask=0: full sequence, no mem_we, completes normally.
- Streak counter:
  - +1 per video grant while cpu_req=1, saturating at STARVE_LIM.
  - Cleared on a CPU grant or whenever cpu_req=0 in IDLE.
- Simultaneous requests with streak<STARVE_LIM: video wins.
- Reset mid-operation: FSM returns to IDLE; the partial transaction is abandoned, no ack, mem_we deasserted immediately.
- Latched operands are stable across ACCESS..DONE; input changes after the grant are ignored.

Decomposition:
- Package rx78_vram_pkg: state enum, owner enum (OWN_CPU, OWN_VID), PLANES/ADDR_W constants, RD_OPEN_BUS=8'hFF.
- One sub-module: vram_rd_bank_sel (rd_bank + 48-bit mem_q -> 8-bit plane byte, FF on invalid).

Test Plan:
- CPU write, wr_mask=6'b000101, addr 0x0123, din 0x5A, no video -> mem_we=000101 for exactly 1 cycle with mem_addr 0x0123; cpu_wait_n high at cycle 2.
- CPU read, rd_bank=3, plane2 holds 0xC3 at 0x0040 -> cpu_dout=0xC3 and cpu_wait_n rises at cycle 3. rd_bank=0 -> 0xFF.
- vid_req and cpu_req asserted in the same cycle -> video granted first (vid_ack at cycle 3, 48-bit data matches all planes); CPU completes at cycle 7.
- vid_req held continuously (new address each ack) with cpu_req high -> exactly 4 video acks, then one CPU completion, then video resumes.
- reset_n pulsed low during WAIT of a CPU read -> no completion; outputs at reset values; cpu_wait_n=1 during reset. After release a held cpu_req is re-serviced from IDLE.
- CPU write with wr_mask=0 -> no mem_we ever; cpu_wait_n released at cycle 2.
